vcve2_agu_seq: RTL and testbench
================================

Name: vcve2_agu_seq

Overview:
- Parametrised, self-sequencing address generation unit for the memory-mapped vector register file (VRF).
- On one start, walks a whole register group word by word. Issues VRF read requests (vs1, vs2) and write requests (vd) over a req/gnt handshake.
- Supports register grouping (LMUL 1/2/4/8) and word-granular slide-up/slide-down with zero-fill.
- Sits between the vector decoder/controller and the VRF memory port.

Parameters:
- AddrWidth, 32, width of addr_o.
- VLEN, 128, bits per vector register; must be a multiple of 32 and at least 32. WPR = VLEN/32 words per register.
- VrfBase, 32'h0000_1000, byte base address of v0 word 0; must be 4-byte aligned.
- OffW, 8, width of offset_i (slide offset in 32-bit words).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- start_i  in  1  start operation; sampled only in IDLE
- vs1_i  in  5  source register 1
- vs2_i  in  5  source register 2
- vd_i  in  5  destination register
- use_vs1_i  in  1  read vs1 each index (normal mode only)
- use_vs2_i  in  1  read vs2 each index
- lmul_i  in  2  group size 2^lmul_i registers
- mode_i  in  2  00 normal, 01 slide-up, 10 slide-down, 11 reserved
- offset_i  in  OffW  slide offset in words
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse coincident with done_o on illegal request
- req_o  out  1  memory request valid
- we_o  out  1  1 = write (vd), 0 = read
- addr_o  out  AddrWidth  request byte address
- zero_fill_o  out  1  current write carries zero data (slide-down tail)
- gnt_i  in  1  request accepted this cycle

Behaviour:
- Interface: clock clk_i; reset rst_ni, asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- Group length: N = WPR << lmul_i. Index counter j runs 0..N-1.
- Address rule: addr_o = VrfBase + ((reg*WPR + w) << 2), where reg is the group base register and w is the word index within the group. Width is truncated to AddrWidth.
- FSM states: IDLE, RD1, RD2, WR, FIN.
- IDLE + start_i:
  - Capture all inputs.
  - If any used register (vd always; vs1/vs2 if used) is not a multiple of 2^lmul_i, or mode_i == 11: go to FIN with err set, no requests.
  - Otherwise set busy_o the next cycle and enter the first active state for the first j.
- Normal mode: j = 0..N-1. Per j: RD1 (if use_vs1) -> RD2 (if use_vs2) -> WR. Read addresses use w = j; write uses w = j.
- Slide-up: j = off..N-1. RD2 at w = j-off, then WR at w = j. Destination words below off receive no request.
- Slide-down: j = 0..N-1.
  - If j+off < N: RD2 at w = j+off, then WR at w = j with zero_fill_o = 0.
  - Else: no read; WR at w = j with zero_fill_o = 1.
- use_vs1_i is ignored in slide modes; use_vs2_i is forced to 1.
- Handshake:
  - req_o, we_o, addr_o and zero_fill_o are registered and remain stable while req_o = 1 and gnt_i = 0.
  - A state advances only on req_o & gnt_i.
  - Back-to-back grants sustain one request per cycle with no bubble between requests.
  - gnt_i while req_o = 0 is ignored.
- Completion: the cycle after the final granted WR, enter FIN. FIN drives done_o = 1 (and err_o if flagged), busy_o = 0 and req_o = 0, then returns to IDLE.
- Degenerate case: slide-up with off >= N goes straight to FIN with no requests and err_o = 0.
- Minimum latency: start to done_o = 1 + (number of requests) cycles, assuming gnt_i is always high.
- start_i while busy is ignored.
- Reset asserted mid-operation: immediately IDLE, outputs 0, no done_o pulse.
- Counters are sized for a group of 8*WPR words; no wrap is possible within legal operation.

Test Plan:
- VLEN=128, lmul=0, normal mode, vs1=3, vs2=4, vd=5, both used, gnt_i tied high -> requests: 0x1030 rd, 0x1040 rd, 0x1050 wr, 0x1034, 0x1044, 0x1054, ... through 0x105C wr. 12 requests total; done_o at cycle 13 after start.
- Slide-down, lmul=0, vs2=2, vd=6, off=1 -> rd 0x1024 / wr 0x1060, rd 0x1028 / wr 0x1064, rd 0x102C / wr 0x1068, then wr 0x106C with zero_fill_o=1. No read at 0x1030.
- Slide-up, lmul=1, vs2=8, vd=10, off=3 (N=8) -> pairs (rd 0x1080 / wr 0x10AC) through (rd 0x1090 / wr 0x10BC). 10 requests total; no write below 0x10AC.
- Stall: gnt_i low for 3 cycles on the second request -> req_o, addr_o and we_o stay constant for those cycles; sequence resumes unchanged; done_o is delayed by 3 cycles.
- Error: lmul=2, vd=6 -> done_o and err_o pulse together; req_o never asserted. Also: slide-up with off=4, lmul=0 -> done_o with err_o=0 and no requests.
- Reset after the 5th grant of the first scenario -> all outputs 0 the next cycle; a new start then reproduces the full sequence from 0x1030.

Source files
------------

// File: rtl/vcve2_agu_seq.sv
// rtl/vcve2_agu_seq.sv - self-sequencing VRF address generator (normal, slide-up, slide-down)
module vcve2_agu_seq #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned VLEN      = 128,
  parameter logic [31:0] VrfBase   = 32'h0000_1000,
  parameter int unsigned OffW      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [4:0]           vs1_i,
  input  logic [4:0]           vs2_i,
  input  logic [4:0]           vd_i,
  input  logic                 use_vs1_i,
  input  logic                 use_vs2_i,
  input  logic [1:0]           lmul_i,
  input  logic [1:0]           mode_i,
  input  logic [OffW-1:0]      offset_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 zero_fill_o,
  input  logic                 gnt_i
);
  localparam int unsigned WPR = VLEN / 32;
  localparam int unsigned CW  = $clog2(8 * WPR) + 1;
  // Wide enough that j+off never overflows for any offset_i value.
  localparam int unsigned SW  = ((CW > OffW) ? CW : OffW) + 1;

  localparam logic [1:0] M_NORM = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DOWN = 2'b10;
  localparam logic [1:0] M_RSV  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_WR, S_FIN} state_e;

  state_e               r_state, w_nxt_state;
  logic [SW-1:0]        r_j, w_nxt_j, r_off, r_n;
  logic [4:0]           r_vs1, r_vs2, r_vd;
  logic                 r_use1, r_use2, r_err;
  logic [1:0]           r_mode;
  logic [AddrWidth-1:0] r_addr;
  logic                 r_we, r_zf;

  logic                 w_idle, w_grant, w_bad, w_go_first, w_nxt_active, w_nxt_zf;
  logic [4:0]           w_vs1, w_vs2, w_vd, w_mask, w_reg;
  logic                 w_use1, w_use2;
  logic [1:0]           w_mode;
  logic [SW-1:0]        w_off, w_n, w_first_j, w_word;
  logic [AddrWidth-1:0] w_addr;

  // In IDLE the request fields come straight from the inputs so the first
  // request can be issued the cycle after start; afterwards the captured copy.
  assign w_idle = (r_state == S_IDLE);
  assign w_vs1  = w_idle ? vs1_i : r_vs1;
  assign w_vs2  = w_idle ? vs2_i : r_vs2;
  assign w_vd   = w_idle ? vd_i : r_vd;
  assign w_mode = w_idle ? mode_i : r_mode;
  assign w_use1 = w_idle ? (use_vs1_i && (mode_i == M_NORM)) : r_use1;
  assign w_use2 = w_idle ? (use_vs2_i || (mode_i != M_NORM)) : r_use2;
  assign w_off  = w_idle ? SW'(offset_i) : r_off;
  assign w_n    = w_idle ? (SW'(WPR) << lmul_i) : r_n;

  always_comb begin
    w_mask = 5'd0;
    case (lmul_i)
      2'd0:    w_mask = 5'd0;
      2'd1:    w_mask = 5'd1;
      2'd2:    w_mask = 5'd3;
      default: w_mask = 5'd7;
    endcase
  end

  assign w_bad = (mode_i == M_RSV) || (|(vd_i & w_mask)) ||
                 (w_use1 && (|(vs1_i & w_mask))) || (w_use2 && (|(vs2_i & w_mask)));
  assign w_grant = req_o && gnt_i;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_j     = r_j;
    w_go_first  = 1'b0;
    w_first_j   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_bad) begin
            w_nxt_state = S_FIN;
          end else if ((mode_i == M_UP) && (w_off >= w_n)) begin
            w_nxt_state = S_FIN;
          end else begin
            w_go_first = 1'b1;
            w_first_j  = (mode_i == M_UP) ? w_off : '0;
          end
        end
      end
      S_RD1: if (w_grant) w_nxt_state = w_use2 ? S_RD2 : S_WR;
      S_RD2: if (w_grant) w_nxt_state = S_WR;
      S_WR: begin
        if (w_grant) begin
          if (r_j + SW'(1) == r_n) begin
            w_nxt_state = S_FIN;
          end else begin
            w_go_first = 1'b1;
            w_first_j  = r_j + SW'(1);
          end
        end
      end
      S_FIN:   w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
    if (w_go_first) begin
      w_nxt_j = w_first_j;
      if (w_mode == M_UP) begin
        w_nxt_state = S_RD2;
      end else if (w_mode == M_DOWN) begin
        w_nxt_state = (w_first_j + w_off < w_n) ? S_RD2 : S_WR;
      end else begin
        w_nxt_state = w_use1 ? S_RD1 : (w_use2 ? S_RD2 : S_WR);
      end
    end
  end

  always_comb begin
    w_reg  = w_vd;
    w_word = w_nxt_j;
    case (w_nxt_state)
      S_RD1: w_reg = w_vs1;
      S_RD2: begin
        w_reg = w_vs2;
        if (w_mode == M_UP)        w_word = w_nxt_j - w_off;
        else if (w_mode == M_DOWN) w_word = w_nxt_j + w_off;
      end
      default: w_reg = w_vd;
    endcase
  end

  assign w_addr       = AddrWidth'(VrfBase + ((32'(w_reg) * WPR + 32'(w_word)) << 2));
  assign w_nxt_active = (w_nxt_state == S_RD1) || (w_nxt_state == S_RD2) || (w_nxt_state == S_WR);
  assign w_nxt_zf     = (w_nxt_state == S_WR) && (w_mode == M_DOWN) && (w_nxt_j + w_off >= w_n);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_off   <= '0;
      r_n     <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_vd    <= '0;
      r_use1  <= 1'b0;
      r_use2  <= 1'b0;
      r_mode  <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_zf    <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_j     <= w_nxt_j;
      if (w_idle && start_i) begin
        r_vs1  <= vs1_i;
        r_vs2  <= vs2_i;
        r_vd   <= vd_i;
        r_use1 <= w_use1;
        r_use2 <= w_use2;
        r_mode <= mode_i;
        r_off  <= w_off;
        r_n    <= w_n;
        r_err  <= w_bad;
      end
      r_addr <= w_nxt_active ? w_addr : '0;
      r_we   <= (w_nxt_state == S_WR);
      r_zf   <= w_nxt_zf;
    end
  end

  assign busy_o      = (r_state == S_RD1) || (r_state == S_RD2) || (r_state == S_WR);
  assign req_o       = busy_o;
  assign done_o      = (r_state == S_FIN);
  assign err_o       = done_o && r_err;
  assign we_o        = r_we;
  assign addr_o      = r_addr;
  assign zero_fill_o = r_zf;
endmodule

// File: tb/tb_vcve2_agu_seq.sv
// tb/tb_vcve2_agu_seq.sv - directed bench for vcve2_agu_seq with hand-computed request streams
module tb_vcve2_agu_seq;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  vs1_i = '0, vs2_i = '0, vd_i = '0;
  logic        use_vs1_i = 1'b0, use_vs2_i = 1'b0;
  logic [1:0]  lmul_i = '0, mode_i = '0;
  logic [7:0]  offset_i = '0;
  logic        gnt_i = 1'b1;
  logic        busy_o, done_o, err_o, req_o, we_o, zero_fill_o;
  logic [31:0] addr_o;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  vcve2_agu_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i),
    .use_vs1_i(use_vs1_i), .use_vs2_i(use_vs2_i),
    .lmul_i(lmul_i), .mode_i(mode_i), .offset_i(offset_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .zero_fill_o(zero_fill_o),
    .gnt_i(gnt_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".req"}, 32'(req_o), 32'd0);
    chk({tag, ".busy"}, 32'(busy_o), 32'd0);
    chk({tag, ".done"}, 32'(done_o), 32'd0);
    chk({tag, ".err"}, 32'(err_o), 32'd0);
    chk({tag, ".we"}, 32'(we_o), 32'd0);
    chk({tag, ".addr"}, addr_o, 32'd0);
    chk({tag, ".zf"}, 32'(zero_fill_o), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge where the first result is visible.
  task automatic start_op(input logic [4:0] v1, input logic [4:0] v2, input logic [4:0] d,
                          input logic u1, input logic u2, input logic [1:0] lm,
                          input logic [1:0] md, input logic [7:0] off);
    vs1_i = v1; vs2_i = v2; vd_i = d; use_vs1_i = u1; use_vs2_i = u2;
    lmul_i = lm; mode_i = md; offset_i = off;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 1;
  endtask

  task automatic step_req(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                          input logic exp_zf);
    chk({tag, ".req"}, 32'(req_o), 32'd1);
    chk({tag, ".busy"}, 32'(busy_o), 32'd1);
    chk({tag, ".we"}, 32'(we_o), 32'(exp_we));
    chk($sformatf("%s@%0h.addr", tag, exp_addr), addr_o, exp_addr);
    chk({tag, ".zf"}, 32'(zero_fill_o), 32'(exp_zf));
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic chk_done(input string tag, input logic exp_err, input int exp_cyc);
    chk({tag, ".done"}, 32'(done_o), 32'd1);
    chk({tag, ".err"}, 32'(err_o), 32'(exp_err));
    chk({tag, ".req"}, 32'(req_o), 32'd0);
    chk({tag, ".busy"}, 32'(busy_o), 32'd0);
    chk({tag, ".latency"}, 32'(cyc), 32'(exp_cyc));
    @(negedge clk_i);
    cyc++;
    chk({tag, ".pulse"}, 32'(done_o), 32'd0);
  endtask

  task automatic normal_seq(input string tag);
    for (int k = 0; k < 4; k++) begin
      step_req({tag, ".rd1"}, 1'b0, 32'h1030 + 32'(4 * k), 1'b0);
      step_req({tag, ".rd2"}, 1'b0, 32'h1040 + 32'(4 * k), 1'b0);
      step_req({tag, ".wr"}, 1'b1, 32'h1050 + 32'(4 * k), 1'b0);
    end
  endtask

  initial begin
    @(negedge clk_i);
    chk_idle_outs("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    start_op(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 2'd0, 2'b00, 8'd0);
    normal_seq("norm");
    chk_done("norm", 1'b0, 13);

    start_op(5'd0, 5'd2, 5'd6, 1'b0, 1'b1, 2'd0, 2'b10, 8'd1);
    step_req("sdn.rd", 1'b0, 32'h1024, 1'b0);
    step_req("sdn.wr", 1'b1, 32'h1060, 1'b0);
    step_req("sdn.rd", 1'b0, 32'h1028, 1'b0);
    step_req("sdn.wr", 1'b1, 32'h1064, 1'b0);
    step_req("sdn.rd", 1'b0, 32'h102C, 1'b0);
    step_req("sdn.wr", 1'b1, 32'h1068, 1'b0);
    step_req("sdn.zfwr", 1'b1, 32'h106C, 1'b1);
    chk_done("sdn", 1'b0, 8);

    start_op(5'd0, 5'd8, 5'd10, 1'b1, 1'b0, 2'd1, 2'b01, 8'd3);
    for (int k = 0; k < 5; k++) begin
      step_req("sup.rd", 1'b0, 32'h1080 + 32'(4 * k), 1'b0);
      step_req("sup.wr", 1'b1, 32'h10AC + 32'(4 * k), 1'b0);
    end
    chk_done("sup", 1'b0, 11);

    // Stall the second request; a start with different operands must be ignored.
    start_op(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 2'd0, 2'b00, 8'd0);
    step_req("stall.rd1", 1'b0, 32'h1030, 1'b0);
    gnt_i = 1'b0;
    start_i = 1'b1;
    vs1_i = 5'd9; vd_i = 5'd1; mode_i = 2'b10;
    for (int k = 0; k < 3; k++) step_req("stall.hold", 1'b0, 32'h1040, 1'b0);
    gnt_i = 1'b1;
    start_i = 1'b0;
    step_req("stall.rd2", 1'b0, 32'h1040, 1'b0);
    step_req("stall.wr", 1'b1, 32'h1050, 1'b0);
    for (int k = 1; k < 4; k++) begin
      step_req("stall.rd1", 1'b0, 32'h1030 + 32'(4 * k), 1'b0);
      step_req("stall.rd2", 1'b0, 32'h1040 + 32'(4 * k), 1'b0);
      step_req("stall.wr", 1'b1, 32'h1050 + 32'(4 * k), 1'b0);
    end
    chk_done("stall", 1'b0, 16);

    start_op(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 2'd2, 2'b00, 8'd0);
    chk_done("misalign", 1'b1, 1);
    chk_idle_outs("misalign.after");

    start_op(5'd0, 5'd0, 5'd4, 1'b0, 1'b1, 2'd0, 2'b01, 8'd4);
    chk_done("upfull", 1'b0, 1);
    chk_idle_outs("upfull.after");

    start_op(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 2'd0, 2'b00, 8'd0);
    step_req("rst.rd1", 1'b0, 32'h1030, 1'b0);
    step_req("rst.rd2", 1'b0, 32'h1040, 1'b0);
    step_req("rst.wr", 1'b1, 32'h1050, 1'b0);
    step_req("rst.rd1", 1'b0, 32'h1034, 1'b0);
    step_req("rst.rd2", 1'b0, 32'h1044, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk_idle_outs("rst.mid");
    @(negedge clk_i);
    chk_idle_outs("rst.held");
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk_idle_outs("rst.released");
    start_op(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 2'd0, 2'b00, 8'd0);
    normal_seq("rerun");
    chk_done("rerun", 1'b0, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
